cnn_layer_accel_trans_eg_arb: RTL and testbench
===============================================

CNN_LAYER_ACCEL_TRANS_EG_ARB -- requirements
Module: cnn_layer_accel_trans_eg_arb

Interface
REQ-001 Parameters (name, default, meaning) SHALL be:
- C_NUM_REQ, 4, number of requesters (2..8).
- C_META_WTH, 64, metadata field width.
- C_PYLD_WTH, 1024, payload field width.
REQ-002 clk  in  1  single clock; all logic SHALL be clocked on its rising edge.
REQ-003 rst  in  1  reset, synchronous, active-high.
REQ-004 req_vld  in  C_NUM_REQ  per-requester beat valid.
REQ-005 req_last  in  C_NUM_REQ  per-requester last beat of packet.
REQ-006 req_meta  in  C_NUM_REQ*C_META_WTH  packed metadata; requester i occupies slice i.
REQ-007 req_pyld  in  C_NUM_REQ*C_PYLD_WTH  packed payload; requester i occupies slice i.
REQ-008 req_rdy  out  C_NUM_REQ  per-requester beat accept.
REQ-009 fifo_din  out  C_META_WTH+C_PYLD_WTH  egress FIFO write data, {meta, pyld} with meta in the MSBs.
REQ-010 fifo_wr_en  out  1  egress FIFO write enable.
REQ-011 fifo_full  in  1  egress FIFO full.
REQ-012 fifo_wr_rst_busy  in  1  egress FIFO write-side reset busy.
REQ-013 grant_id  out  clog2(C_NUM_REQ)  index of the currently granted requester.
REQ-014 busy  out  1  high while in the XFER state.
REQ-015 pkt_cnt  out  16  count of completed packets.

Function
REQ-016 The FSM SHALL have two states, IDLE and XFER.
REQ-017 IDLE arbitration:
- Arbitration SHALL run only when any req_vld is high and fifo_full=0 and fifo_wr_rst_busy=0.
- Selection SHALL be round-robin, searching upward from (last_grant+1) mod C_NUM_REQ.
- The winner SHALL be registered into grant_id and last_grant, and the FSM SHALL enter XFER on the next cycle.
REQ-018 In IDLE, req_rdy SHALL be all-zero and fifo_wr_en SHALL be 0.
REQ-019 In XFER, req_rdy[grant_id] SHALL equal !fifo_full && !fifo_wr_rst_busy, and every other req_rdy bit SHALL be 0.
REQ-020 Beat acceptance:
- A beat is accepted when req_vld[g] && req_rdy[g], with g = grant_id.
- On acceptance, fifo_wr_en SHALL be 1 combinationally in the same cycle (zero-latency pass-through).
- fifo_din SHALL carry slice g of req_meta and req_pyld.
REQ-021 fifo_wr_en SHALL never be asserted while fifo_full=1 or fifo_wr_rst_busy=1.
REQ-022 Grant SHALL be packet-atomic: it is held through any req_vld deassertion or backpressure until a beat with req_last[g]=1 is accepted.
REQ-023 Accepting the last beat SHALL return the FSM to IDLE and increment pkt_cnt by 1 on the next edge.
- Back-to-back packets therefore SHALL incur exactly one idle cycle between them.
REQ-024 pkt_cnt SHALL wrap from 0xFFFF to 0x0000.
REQ-025 A requester SHALL be able to win again only after every other requester that is asserting req_vld has been granted once.
REQ-026 Single-beat packets (req_vld and req_last high together) SHALL complete in one XFER cycle.
REQ-027 req_last on a non-granted requester SHALL be ignored.

Reset
REQ-028 On rst=1, on the next edge:
- state SHALL be IDLE.
- grant_id SHALL be 0.
- last_grant SHALL be C_NUM_REQ-1, so requester 0 has first priority.
- pkt_cnt SHALL be 0.
- busy, req_rdy and fifo_wr_en SHALL be 0.
REQ-029 A reset asserted mid-packet SHALL abandon the packet with no further fifo_wr_en and SHALL NOT increment pkt_cnt.
REQ-030 rst SHALL take priority over every other event in the same cycle.

Structure
REQ-031 C_META_WTH/C_PYLD_WTH defaults, the FSM state enum and the {meta, pyld} packing order SHALL reside in the shared trans FIFO package/header used by the egress FIFO.
REQ-032 The round-robin selector SHALL be a sub-module, cnn_layer_accel_rr_arb (request vector and last-grant in, one-hot plus index out, combinational).
REQ-033 The block SHALL be sized for 120-400 lines of RTL and SHALL contain no FIFO storage.

Verification
REQ-034 The bench SHALL cover these directed scenarios:
- Reset, then req 0 sends a 3-beat packet -> 3 fifo_wr_en pulses with matching {meta, pyld}; pkt_cnt=1; grant_id=0.
- Reqs 0..3 each hold a 2-beat packet simultaneously -> grant order 0,1,2,3; one idle cycle between packets; pkt_cnt=4.
- fifo_full held high for 5 cycles mid-packet from req 2 -> req_rdy[2]=0 and fifo_wr_en=0 for those 5 cycles; packet resumes intact.
- Req 1 drops req_vld for 3 cycles mid-packet while req 3 is valid -> grant stays on 1 until its last beat.
- rst pulsed during beat 2 of a 4-beat packet -> no further writes; pkt_cnt=0; next grant goes to req 0.
- pkt_cnt preloaded by 65535 single-beat packets, then one more -> pkt_cnt=0.

Source files
------------

// File: rtl/cnn_layer_accel_trans_eg_arb_pkg.sv
// cnn_layer_accel_trans_eg_arb_pkg: shared trans-FIFO widths and arbiter states; FIFO words are {meta, pyld}, meta in the MSBs
package cnn_layer_accel_trans_eg_arb_pkg;
  localparam int C_META_WTH_DEF = 64;
  localparam int C_PYLD_WTH_DEF = 1024;
  typedef enum logic {IDLE, XFER} arb_state_e;
endpackage

// File: rtl/cnn_layer_accel_rr_arb.sv
// cnn_layer_accel_rr_arb: combinational round-robin pick searching upward from last grant + 1
module cnn_layer_accel_rr_arb #(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] last_i,
  output logic [N-1:0]  gnt_oh_o,
  output logic [IW-1:0] gnt_idx_o
);
  logic [IW-1:0] idx;
  always_comb begin
    gnt_oh_o  = '0;
    gnt_idx_o = '0;
    idx       = '0;
    // walk from farthest to nearest so the nearest requester after last_i wins
    for (int k = N; k >= 1; k--) begin
      idx = IW'((int'(last_i) + k) % N);
      gnt_idx_o = req_i[idx] ? idx : gnt_idx_o;
    end
    gnt_oh_o[gnt_idx_o] = |req_i;
  end
endmodule

// File: rtl/cnn_layer_accel_trans_eg_arb.sv
// cnn_layer_accel_trans_eg_arb: packet-atomic round-robin arbiter feeding the egress trans FIFO
module cnn_layer_accel_trans_eg_arb
  import cnn_layer_accel_trans_eg_arb_pkg::*;
#(
  parameter int C_NUM_REQ  = 4,
  parameter int C_META_WTH = C_META_WTH_DEF,
  parameter int C_PYLD_WTH = C_PYLD_WTH_DEF,
  localparam int IW = $clog2(C_NUM_REQ)
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [C_NUM_REQ-1:0]             req_vld,
  input  logic [C_NUM_REQ-1:0]             req_last,
  input  logic [C_NUM_REQ*C_META_WTH-1:0]  req_meta,
  input  logic [C_NUM_REQ*C_PYLD_WTH-1:0]  req_pyld,
  output logic [C_NUM_REQ-1:0]             req_rdy,
  output logic [C_META_WTH+C_PYLD_WTH-1:0] fifo_din,
  output logic                             fifo_wr_en,
  input  logic                             fifo_full,
  input  logic                             fifo_wr_rst_busy,
  output logic [IW-1:0]                    grant_id,
  output logic                             busy,
  output logic [15:0]                      pkt_cnt
);
  arb_state_e state_q, state_d;
  logic [IW-1:0] grant_q, grant_d, last_q, last_d, arb_idx;
  logic [C_NUM_REQ-1:0] arb_oh;
  logic [15:0] pkt_cnt_q, pkt_cnt_d;
  logic fifo_ok, acc, win, done;

  cnn_layer_accel_rr_arb #(.N(C_NUM_REQ)) u_rr_arb (
    .req_i    (req_vld),
    .last_i   (last_q),
    .gnt_oh_o (arb_oh),
    .gnt_idx_o(arb_idx)
  );

  // rst masks the handshake so a reset cycle can never leak a write
  assign fifo_ok    = !fifo_full && !fifo_wr_rst_busy && !rst;
  assign acc        = state_q == XFER && fifo_ok && req_vld[grant_q];
  assign win        = state_q == IDLE && |arb_oh && fifo_ok;
  assign done       = acc && req_last[grant_q];
  assign fifo_wr_en = acc;
  assign busy       = state_q == XFER;
  assign grant_id   = grant_q;
  assign pkt_cnt    = pkt_cnt_q;

  always_comb begin
    req_rdy          = '0;
    req_rdy[grant_q] = state_q == XFER && fifo_ok;
    fifo_din         = '0;
    for (int i = 0; i < C_NUM_REQ; i++)
      fifo_din = grant_q == IW'(i) ? {req_meta[i*C_META_WTH +: C_META_WTH], req_pyld[i*C_PYLD_WTH +: C_PYLD_WTH]} : fifo_din;
  end

  always_comb begin
    state_d   = win ? XFER : done ? IDLE : state_q;
    grant_d   = win ? arb_idx : grant_q;
    last_d    = win ? arb_idx : last_q;
    pkt_cnt_d = done ? pkt_cnt_q + 16'd1 : pkt_cnt_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      grant_q   <= '0;
      last_q    <= IW'(C_NUM_REQ - 1);
      pkt_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      last_q    <= last_d;
      pkt_cnt_q <= pkt_cnt_d;
    end
  end
endmodule

// File: tb/tb_cnn_layer_accel_trans_eg_arb.sv
// tb_cnn_layer_accel_trans_eg_arb: randomized + directed bench with packet-level reference model and scoreboard
module tb_cnn_layer_accel_trans_eg_arb;
  localparam int NR = 4, MW = 16, PW = 32, IW = 2, DW = MW + PW;
  typedef struct { logic [MW-1:0] meta; logic [PW-1:0] pyld; logic last; } beat_t;
  typedef struct { logic wr; logic [DW-1:0] din; logic [NR-1:0] rdy; logic [IW-1:0] grant; logic busy; logic [15:0] cnt; } exp_t;
  logic clk = 1'b0, rst = 1'b1;
  logic [NR-1:0] req_vld = '0, req_last = '0, req_rdy;
  logic [NR*MW-1:0] req_meta = '0;
  logic [NR*PW-1:0] req_pyld = '0;
  logic [DW-1:0] fifo_din;
  logic fifo_wr_en, busy, fifo_full = 1'b0, fifo_wr_rst_busy = 1'b0;
  logic [IW-1:0] grant_id;
  logic [15:0] pkt_cnt;
  int checks = 0, errors = 0, wr_count = 0, preload_req = 0, preload_seen = 0;
  beat_t src_q[NR][$];
  exp_t exp_q[$];
  int gnt_log[$];
  logic [NR-1:0] hold = '0;
  logic rnd = 1'b0, force_full = 1'b0;
  int m_grant = 0, m_last = NR - 1;
  logic m_busy = 1'b0;
  logic [15:0] m_cnt = '0;

  cnn_layer_accel_trans_eg_arb #(.C_NUM_REQ(NR), .C_META_WTH(MW), .C_PYLD_WTH(PW)) dut (
    .clk(clk), .rst(rst), .req_vld(req_vld), .req_last(req_last), .req_meta(req_meta),
    .req_pyld(req_pyld), .req_rdy(req_rdy), .fifo_din(fifo_din), .fifo_wr_en(fifo_wr_en),
    .fifo_full(fifo_full), .fifo_wr_rst_busy(fifo_wr_rst_busy), .grant_id(grant_id),
    .busy(busy), .pkt_cnt(pkt_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic bit_at(logic [NR-1:0] v, int i);
    logic [NR-1:0] t;
    t = v >> i;
    return t[0];
  endfunction

  function automatic void check(string nm, logic [63:0] got, logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, got, want, $time);
    end
  endfunction

  // reference model: one expected output record per cycle, derived from packet-level arbitration rules
  initial begin
    exp_t e;
    logic ok;
    logic do_force;
    @(posedge clk);
    forever begin
      @(negedge clk);
      do_force = 1'b0;
      ok = !fifo_full && !fifo_wr_rst_busy && !rst;
      e.busy  = m_busy;
      e.grant = IW'(m_grant);
      e.cnt   = m_cnt;
      e.rdy   = (m_busy && ok) ? NR'(1) << m_grant : '0;
      e.wr    = m_busy && ok && bit_at(req_vld, m_grant);
      e.din   = {req_meta[m_grant*MW +: MW], req_pyld[m_grant*PW +: PW]};
      exp_q.push_back(e);
      if (preload_req != preload_seen) begin
        m_cnt = 16'hFFFF;
        preload_seen++;
        do_force = 1'b1;
      end
      if (rst) begin
        m_busy = 1'b0; m_grant = 0; m_last = NR - 1; m_cnt = '0;
      end else if (!m_busy) begin
        if (req_vld != '0 && ok) begin
          for (int k = 1; k <= NR; k++)
            if (bit_at(req_vld, (m_last + k) % NR)) begin
              m_grant = (m_last + k) % NR;
              break;
            end
          m_last = m_grant;
          m_busy = 1'b1;
        end
      end else if (e.wr && bit_at(req_last, m_grant)) begin
        m_busy = 1'b0;
        m_cnt  = m_cnt + 16'd1;
      end
      if (do_force) begin
        #2 force dut.pkt_cnt_q = 16'hFFFF;
        #1 release dut.pkt_cnt_q;
      end
    end
  end

  // monitor: pops one expected record per cycle and compares against the DUT outputs
  initial begin
    exp_t e;
    @(posedge clk);
    forever begin
      @(negedge clk);
      #1;
      if (exp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL scoreboard: no expected record at t=%0t", $time);
      end else begin
        e = exp_q.pop_front();
        check("fifo_wr_en", 64'(fifo_wr_en), 64'(e.wr));
        check("req_rdy", 64'(req_rdy), 64'(e.rdy));
        check("busy", 64'(busy), 64'(e.busy));
        check("grant_id", 64'(grant_id), 64'(e.grant));
        check("pkt_cnt", 64'(pkt_cnt), 64'(e.cnt));
        if (e.wr) check("fifo_din", 64'(fifo_din), 64'(e.din));
      end
      if (fifo_wr_en) begin
        wr_count++;
        gnt_log.push_back(int'(grant_id));
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic add_pkt(input int i, input int n);
    for (int b = 0; b < n; b++) src_q[i].push_back('{MW'($urandom), PW'($urandom), b == n - 1});
  endtask

  task automatic drive();
    logic [NR-1:0] vv, ll;
    vv = '0; ll = '0;
    for (int i = 0; i < NR; i++) begin
      if (src_q[i].size() > 0) begin
        if (!bit_at(hold, i) && (!rnd || $urandom_range(0, 3) != 0)) vv = vv | (NR'(1) << i);
        if (src_q[i][0].last) ll = ll | (NR'(1) << i);
        req_meta[i*MW +: MW] = src_q[i][0].meta;
        req_pyld[i*PW +: PW] = src_q[i][0].pyld;
      end else begin
        if ($urandom_range(0, 1) == 1) ll = ll | (NR'(1) << i);
        req_meta[i*MW +: MW] = MW'($urandom);
        req_pyld[i*PW +: PW] = PW'($urandom);
      end
    end
    req_vld = vv;
    req_last = ll;
    fifo_full = force_full || (rnd && $urandom_range(0, 4) == 0);
    fifo_wr_rst_busy = rnd && $urandom_range(0, 19) == 0;
  endtask

  task automatic step();
    logic [NR-1:0] acc;
    @(negedge clk);
    acc = req_vld & req_rdy;
    @(posedge clk);
    #1;
    for (int i = 0; i < NR; i++)
      if (rst) src_q[i].delete();
      else if (bit_at(acc, i)) void'(src_q[i].pop_front());
    drive();
  endtask

  function automatic int pending();
    int s = 0;
    for (int i = 0; i < NR; i++) s += src_q[i].size();
    return s;
  endfunction

  task automatic wait_done(input int max);
    int n = 0;
    while (pending() > 0 && n < max) begin step(); n++; end
    if (pending() > 0) begin
      checks++; errors++;
      $display("FAIL wait_done: %0d beats pending after %0d cycles", pending(), max);
      for (int i = 0; i < NR; i++) src_q[i].delete();
    end
    repeat (3) step();
  endtask

  task automatic wait_wr(input int target, input int max);
    int n = 0;
    while (wr_count < target && n < max) begin step(); n++; end
    if (wr_count < target) begin
      checks++; errors++;
      $display("FAIL wait_wr: got %0d writes expected %0d", wr_count, target);
    end
  endtask

  initial begin
    int w0, w1, base, npk, r;
    drive();
    repeat (3) step();
    check("reset_busy", 64'(busy), 64'(0));
    check("reset_rdy", 64'(req_rdy), 64'(0));
    check("reset_cnt", 64'(pkt_cnt), 64'(0));
    rst = 1'b0;
    // single 3-beat packet from requester 0
    w0 = wr_count;
    add_pkt(0, 3); drive();
    wait_done(50);
    check("s1_writes", 64'(wr_count - w0), 64'(3));
    check("s1_pkt_cnt", 64'(pkt_cnt), 64'(1));
    check("s1_grant", 64'(grant_id), 64'(0));
    // all four requesters with 2-beat packets after a fresh reset
    rst = 1'b1; step(); step(); rst = 1'b0;
    base = gnt_log.size();
    for (int i = 0; i < NR; i++) add_pkt(i, 2);
    drive();
    wait_done(100);
    check("s2_nwr", 64'(gnt_log.size() - base), 64'(8));
    for (int k = 0; k < 8; k++)
      if (base + k < gnt_log.size()) check("s2_order", 64'(gnt_log[base + k]), 64'(k / 2));
    check("s2_pkt_cnt", 64'(pkt_cnt), 64'(4));
    // fifo_full stall mid-packet on requester 2
    w0 = wr_count;
    add_pkt(2, 4); drive();
    wait_wr(w0 + 1, 20);
    force_full = 1'b1; drive();
    w1 = wr_count;
    repeat (5) step();
    check("s3_stall_writes", 64'(wr_count - w1), 64'(0));
    force_full = 1'b0; drive();
    wait_done(50);
    check("s3_total", 64'(wr_count - w0), 64'(4));
    check("s3_pkt_cnt", 64'(pkt_cnt), 64'(5));
    // requester 1 pauses mid-packet while requester 3 waits
    base = gnt_log.size();
    w0 = wr_count;
    add_pkt(1, 4); drive();
    wait_wr(w0 + 1, 20);
    add_pkt(3, 2); hold[1] = 1'b1; drive();
    repeat (3) step();
    hold[1] = 1'b0; drive();
    wait_done(50);
    check("s4_nwr", 64'(gnt_log.size() - base), 64'(6));
    for (int k = 0; k < 6; k++)
      if (base + k < gnt_log.size()) check("s4_order", 64'(gnt_log[base + k]), 64'(k < 4 ? 1 : 3));
    check("s4_pkt_cnt", 64'(pkt_cnt), 64'(7));
    // reset during beat 2 of a 4-beat packet
    w0 = wr_count;
    add_pkt(0, 4); drive();
    wait_wr(w0 + 1, 20);
    rst = 1'b1; step(); rst = 1'b0;
    repeat (4) step();
    check("s5_writes", 64'(wr_count - w0), 64'(1));
    check("s5_pkt_cnt", 64'(pkt_cnt), 64'(0));
    base = gnt_log.size();
    add_pkt(2, 1); add_pkt(0, 1); drive();
    wait_done(30);
    check("s5_nwr", 64'(gnt_log.size() - base), 64'(2));
    if (gnt_log.size() >= base + 2) begin
      check("s5_first", 64'(gnt_log[base]), 64'(0));
      check("s5_second", 64'(gnt_log[base + 1]), 64'(2));
    end
    // randomized traffic with gaps and backpressure
    rnd = 1'b1; npk = 0;
    repeat (1500) begin
      if ($urandom_range(0, 5) == 0) begin
        r = $urandom_range(0, NR - 1);
        if (src_q[r].size() < 8) begin add_pkt(r, $urandom_range(1, 4)); npk++; end
      end
      step();
    end
    rnd = 1'b0; drive();
    wait_done(500);
    check("rand_pkt_cnt", 64'(pkt_cnt), 64'(16'(2 + npk)));
    // counter wrap from 0xFFFF
    preload_req++;
    step(); step();
    check("preload_cnt", 64'(pkt_cnt), 64'(16'hFFFF));
    add_pkt(1, 1); drive();
    wait_done(20);
    check("wrap_cnt", 64'(pkt_cnt), 64'(0));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
